// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_arb_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF  = 32;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;
    localparam int unsigned REQ_MDU = 2;

    // Pointer width that still works for a single requester.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: search upward from ptr with wrap, first valid wins.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   ptr_nxt
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!found && valid[PTR_W'(idx)]) begin
                grant[PTR_W'(idx)] = 1'b1;
                ptr_nxt            = PTR_W'((idx + 1) % NUM_REQ);
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter with registered regfile write stage and RAW busy scoreboard.
// Optional macro RF_WB_PERF_EN adds a saturating conflict_cnt output.
module regfile_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       claim_valid,
    input  logic [ADDR_W-1:0]          claim_addr,
    input  logic [ADDR_W-1:0]          chk_addr1,
    input  logic [ADDR_W-1:0]          chk_addr2,
    output logic                       chk_busy1,
    output logic                       chk_busy2,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata
`ifdef RF_WB_PERF_EN
    ,
    output logic [15:0]                conflict_cnt
`endif
);

    localparam int unsigned PTR_W    = ptr_width(NUM_REQ);
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [PTR_W-1:0]    ptr_q, ptr_d, ptr_nxt;
    logic [NUM_REQ-1:0]  grant;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid   (req_valid),
        .ptr     (ptr_q),
        .grant   (grant),
        .ptr_nxt (ptr_nxt)
    );

    assign req_ready = rst ? '0 : grant;
    assign accept    = |req_ready;

    // One-hot select of the granted requester's payload.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state: output stage, pointer, scoreboard (claim applied last so it wins).
    always_comb begin
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        busy_d     = busy_q;
        if (accept) begin
            ptr_d      = ptr_nxt;
            rf_we_d    = (sel_addr != ZERO_A);
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
            if (sel_addr != ZERO_A) begin
                busy_d[sel_addr] = 1'b0;
            end
        end
        if (claim_valid && (claim_addr != ZERO_A)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign chk_busy1 = busy_q[chk_addr1] && (chk_addr1 != ZERO_A);
    assign chk_busy2 = busy_q[chk_addr2] && (chk_addr2 != ZERO_A);

`ifdef RF_WB_PERF_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // Saturating count of cycles with two or more simultaneous requests.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (($countones(req_valid) >= 2) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ writeback sources: ALU = 0, load unit = 1, mul/div = 2.
- Registers the granted write into a one-entry output stage that drives the regfile we/waddr/wdata. The regfile commits on the negedge of the same cycle.
- Keeps a 32-bit busy scoreboard: a long-latency issue claims its destination, and the commit clears it. Decode uses the busy bits to stall on RAW hazards.

Parameters:
- NUM_REQ, 3, number of writeback requesters.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational; a transfer happens when valid and ready are both 1.
- claim_valid  in  1  issue of a long-latency producer.
- claim_addr  in  ADDR_W  destination register being claimed.
- chk_addr1  in  ADDR_W  decode source operand 1.
- chk_addr2  in  ADDR_W  decode source operand 2.
- chk_busy1  out  1  combinational; equals busy[chk_addr1] AND chk_addr1 != 0.
- chk_busy2  out  1  combinational; equals busy[chk_addr2] AND chk_addr2 != 0.
- rf_we  out  1  registered regfile write enable.
- rf_waddr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.

Behaviour:
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, round-robin pointer=0.
  - Reset mid-operation discards any write that has been accepted but not yet committed.
  - req_ready is 0 while rst is high.
- Arbitration is round-robin.
  - Search starts at the pointer and runs upward, wrapping modulo NUM_REQ; the first valid requester is granted.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
  - With no valid request, the pointer holds.
- At most one grant per cycle. req_ready is independent of the output stage (no backpressure); the regfile accepts one write per cycle.
- Latency:
  - A write accepted at posedge N appears on rf_* during cycle N..N+1.
  - The regfile writes at the negedge inside that cycle.
  - With no acceptance, rf_we=0 and rf_waddr/rf_wdata hold their values.
- Address 0 handling:
  - A request to address 0 is accepted (ready asserted, pointer advances) but rf_we stays 0.
  - Claims of address 0 are ignored; busy[0] is always 0.
- Scoreboard:
  - claim_valid && claim_addr!=0 sets busy[claim_addr] at posedge.
  - An accepted write to a nonzero address clears busy[addr] at the accepting posedge.
  - Simultaneous claim and commit to the same address: the claim wins and the bit stays 1.
  - Claiming an already busy register leaves it at 1; there is no count.
  - A commit to a register that is not busy is legal and has no scoreboard effect.
- A requester holding valid without a grant must keep addr/data stable. Starvation is bounded at NUM_REQ-1 cycles.

Optional Feature:
- Macro RF_WB_PERF_EN.
- When defined:
  - Extra output port conflict_cnt (16 bits).
  - It counts cycles with two or more req_valid bits high, saturates at 16'hFFFF, and resets to 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package rf_arb_pkg:
  - ADDR_W/DATA_W/NUM_REQ defaults.
  - REG_ZERO constant (5'd0).
  - Requester index constants REQ_ALU=0, REQ_MEM=1, REQ_MDU=2.
- Sub-module rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: valid vector, pointer. Outputs: one-hot grant, next pointer.
  - Purely combinational; the pointer register stays in regfile_wb_arbiter.

Test Plan:
- Reset then idle, with rst pulsed asynchronously mid-cycle → all outputs 0 immediately; chk_busy1/2=0 for every address.
- Single ALU request (addr 5, data 32'hDEADBEEF), valid one cycle → req_ready=3'b001 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF; the cycle after, rf_we=0.
- All three valid, held for 6 cycles from reset → grant sequence 0,1,2,0,1,2; rf_waddr follows the corresponding addresses; with RF_WB_PERF_EN, conflict_cnt=6.
- Claim addr 9, then check chk_addr1=9 → chk_busy1=1; MDU writes addr 9 three cycles later → busy clears the cycle after acceptance; rf_we=1 with waddr 9.
- Same-cycle claim addr 12 and accepted commit addr 12 → busy[12] stays 1; a claim and a write to addr 0 → busy[0]=0, rf_we=0, and the pointer still advances.
- Write accepted, then rst asserted before the next posedge → rf_we forced 0 and the regfile is not written.
